// File: rtl/button_conditioner.sv
// Push-button front end: synchronise, debounce and edge-detect Up/Down/TC/Lp for the VGA colour controller.
// Define BTN_AUTOREPEAT_EN to add hold-to-repeat on the Up and Down strobes.
module button_conditioner #(
    parameter int unsigned DEBOUNCE_CYCLES = 500000,
    parameter int unsigned CNT_W           = 19,
    parameter int unsigned REPEAT_DELAY    = 25000000,
    parameter int unsigned REPEAT_PERIOD   = 5000000
) (
    input  logic Clock,
    input  logic reset,
    input  logic btn_up,
    input  logic btn_down,
    input  logic btn_tc,
    input  logic btn_lp,
    output logic Up,
    output logic Down,
    output logic TC,
    output logic Lp
);

    localparam int unsigned NCH     = 4;
    localparam int unsigned CH_UP   = 0;
    localparam int unsigned CH_DOWN = 1;
    localparam int unsigned CH_TC   = 2;
    localparam int unsigned CH_LP   = 3;

    // Reject parameter sets the counters cannot represent.
    if (DEBOUNCE_CYCLES < 2 || (64'(1) << CNT_W) <= 64'(DEBOUNCE_CYCLES) ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_params
        $error("button_conditioner: illegal parameter combination");
    end

    logic [NCH-1:0]   raw;
    logic [NCH-1:0]   s1;
    logic [NCH-1:0]   s2;
    logic [NCH-1:0]   st;
    logic [CNT_W-1:0] cnt [NCH];

    logic [1:0] dir_st;
    logic [1:0] other_st;
    logic [1:0] st_d;
    logic [1:0] rise;
    logic [1:0] press;
    logic [1:0] strobe_c;

    assign raw = {btn_lp, btn_tc, btn_down, btn_up};

    // Two-flop synchroniser, then a per-channel run-length counter that flips st after a stable run.
    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            s1 <= '0;
            s2 <= '0;
            st <= '0;
            for (int i = 0; i < NCH; i++) begin
                cnt[i] <= '0;
            end
        end else begin
            s1 <= raw;
            s2 <= s1;
            for (int i = 0; i < NCH; i++) begin
                if (s2[i] == st[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                    st[i]  <= ~st[i];
                    cnt[i] <= '0;
                end else begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // Bit 0 is the Up direction, bit 1 the Down direction.
    assign dir_st   = {st[CH_DOWN], st[CH_UP]};
    assign other_st = {st[CH_UP], st[CH_DOWN]};
    assign rise     = dir_st & ~st_d;
    assign press    = rise & ~other_st;

`ifdef BTN_AUTOREPEAT_EN
    localparam int unsigned RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned RPT_W   = (RPT_MAX < 2) ? 1 : $clog2(RPT_MAX);

    typedef enum logic [1:0] {
        RPT_IDLE   = 2'd0,
        RPT_DELAY  = 2'd1,
        RPT_REPEAT = 2'd2
    } rpt_state_e;

    rpt_state_e       rpt_state   [2];
    rpt_state_e       rpt_state_n [2];
    logic [RPT_W-1:0] rpt         [2];
    logic [RPT_W-1:0] rpt_n       [2];
    logic [1:0]       other_rise;
    logic [1:0]       cancel;

    assign other_rise = {rise[0], rise[1]};
    assign cancel     = ~dir_st | other_rise;

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            for (int d = 0; d < 2; d++) begin
                rpt_state[d] <= RPT_IDLE;
                rpt[d]       <= '0;
            end
        end else begin
            for (int d = 0; d < 2; d++) begin
                rpt_state[d] <= rpt_state_n[d];
                rpt[d]       <= rpt_n[d];
            end
        end
    end

    // Release or an opposing press abandons a repeat run without a final strobe.
    always_comb begin
        strobe_c = '0;
        for (int d = 0; d < 2; d++) begin
            rpt_state_n[d] = rpt_state[d];
            rpt_n[d]       = rpt[d];
            case (rpt_state[d])
                RPT_IDLE: begin
                    if (press[d]) begin
                        strobe_c[d]    = 1'b1;
                        rpt_state_n[d] = RPT_DELAY;
                        rpt_n[d]       = RPT_W'(REPEAT_DELAY - 1);
                    end
                end
                RPT_DELAY, RPT_REPEAT: begin
                    if (cancel[d]) begin
                        rpt_state_n[d] = RPT_IDLE;
                    end else if (rpt[d] == '0) begin
                        strobe_c[d]    = 1'b1;
                        rpt_state_n[d] = RPT_REPEAT;
                        rpt_n[d]       = RPT_W'(REPEAT_PERIOD - 1);
                    end else begin
                        rpt_n[d] = rpt[d] - RPT_W'(1);
                    end
                end
                default: begin
                    rpt_state_n[d] = RPT_IDLE;
                end
            endcase
        end
    end
`else
    assign strobe_c = press;
`endif

    always_ff @(posedge Clock or negedge reset) begin
        if (!reset) begin
            st_d <= '0;
            Up   <= 1'b0;
            Down <= 1'b0;
        end else begin
            st_d <= dir_st;
            Up   <= strobe_c[0];
            Down <= strobe_c[1];
        end
    end

    assign TC = st[CH_TC];
    assign Lp = st[CH_LP];

endmodule

// File: tb/tb_button_conditioner.sv
// Bench for button_conditioner: directed scenarios plus random button activity against a window-based reference model.
module tb_button_conditioner;

    localparam int unsigned D  = 8;
    localparam int unsigned CW = 4;
    localparam int unsigned RD = 20;
    localparam int unsigned RP = 6;

    logic Clock    = 1'b0;
    logic reset    = 1'b1;
    logic btn_up   = 1'b0;
    logic btn_down = 1'b0;
    logic btn_tc   = 1'b0;
    logic btn_lp   = 1'b0;
    logic Up, Down, TC, Lp;

    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    button_conditioner #(
        .DEBOUNCE_CYCLES (D),
        .CNT_W           (CW),
        .REPEAT_DELAY    (RD),
        .REPEAT_PERIOD   (RP)
    ) dut (
        .Clock    (Clock),
        .reset    (reset),
        .btn_up   (btn_up),
        .btn_down (btn_down),
        .btn_tc   (btn_tc),
        .btn_lp   (btn_lp),
        .Up       (Up),
        .Down     (Down),
        .TC       (TC),
        .Lp       (Lp)
    );

    // Reference model: a level is accepted once the last D synchronised samples all disagree with it.
    logic [3:0]   m_p1, m_p2, m_lvl, m_lvl_p;
    logic [D-1:0] m_hist [4];
    logic [1:0]   m_strobe;
    bit           m_eng [2];
    int           m_first [2];
    int           m_cyc = 0;
    logic [3:0]   exp_out;

    task automatic model_clear();
        m_p1     = '0;
        m_p2     = '0;
        m_lvl    = '0;
        m_lvl_p  = '0;
        m_strobe = '0;
        exp_out  = '0;
        for (int c = 0; c < 4; c++) m_hist[c] = '0;
        for (int d = 0; d < 2; d++) begin
            m_eng[d]   = 1'b0;
            m_first[d] = 0;
        end
    endtask

    task automatic tick();
        logic [3:0] raw;
        logic       rise_d, rise_o, press;
        int         o;
        int         el;
        @(posedge Clock);
        raw = {btn_lp, btn_tc, btn_down, btn_up};
        m_cyc++;
        el = 0;
        if (!reset) begin
            model_clear();
        end else begin
            for (int d = 0; d < 2; d++) begin
                o      = 1 - d;
                rise_d = m_lvl[d] & ~m_lvl_p[d];
                rise_o = m_lvl[o] & ~m_lvl_p[o];
                press  = rise_d & ~m_lvl[o];
`ifdef BTN_AUTOREPEAT_EN
                if (!m_eng[d]) begin
                    m_strobe[d] = press;
                    if (press) begin
                        m_eng[d]   = 1'b1;
                        m_first[d] = m_cyc;
                    end
                end else if (!m_lvl[d] || rise_o) begin
                    m_eng[d]    = 1'b0;
                    m_strobe[d] = 1'b0;
                end else begin
                    el          = m_cyc - m_first[d];
                    m_strobe[d] = (el >= int'(RD)) && ((el - int'(RD)) % int'(RP) == 0);
                end
`else
                m_strobe[d] = press;
                if (rise_o) m_eng[d] = 1'b0;
`endif
            end
            m_lvl_p = m_lvl;
            for (int c = 0; c < 4; c++) begin
                m_hist[c] = {m_hist[c][D-2:0], m_p2[c]};
                if (m_hist[c] == {D{~m_lvl[c]}}) m_lvl[c] = ~m_lvl[c];
            end
            m_p2 = m_p1;
            m_p1 = raw;
        end
        exp_out = {m_strobe[0], m_strobe[1], m_lvl[2], m_lvl[3]};
        #1;
    endtask

    task automatic test_reset();
        int n;
        n = 0;
        reset = 1'b1;
        #1;
        reset = 1'b0;
        model_clear();
        #2;
        checks++;
        if ({Up, Down, TC, Lp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_async: got %b expected 0000", {Up, Down, TC, Lp});
        end
        repeat (3) tick();
        checks++;
        if ({Up, Down, TC, Lp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_hold: got %b expected 0000", {Up, Down, TC, Lp});
        end
        reset = 1'b1;
        repeat (100) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL idle_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (Up || Down) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL idle_no_strobe: got %0d strobes expected 0", n);
        end
    endtask

    task automatic test_bounce();
        int nb, ns, first_t;
        nb = 0;
        ns = 0;
        first_t = -1;
        for (int i = 0; i < 12; i++) begin
            btn_up = ~btn_up;
            repeat (3) begin
                tick();
                checks++;
                if ({Up, Down, TC, Lp} !== exp_out) begin
                    errors++;
                    $display("FAIL bounce_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
                end
                if (Up) nb++;
            end
        end
        btn_up = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL bounce_hold_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (Up) begin
                ns++;
                if (first_t < 0) first_t = t;
            end
        end
        checks++;
        if (nb != 0) begin
            errors++;
            $display("FAIL bounce_quiet: got %0d strobes expected 0", nb);
        end
        checks++;
        if (ns != 1) begin
            errors++;
            $display("FAIL bounce_one_strobe: got %0d strobes expected 1", ns);
        end
        checks++;
        if (first_t != 11) begin
            errors++;
            $display("FAIL bounce_latency: got %0d cycles expected 11", first_t);
        end
        btn_up = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_combo();
        int tc_rise, up_t, nu;
        logic up_tc;
        tc_rise = -1;
        up_t = -1;
        nu = 0;
        up_tc = 1'b0;
        btn_tc = 1'b1;
        btn_up = 1'b1;
        for (int t = 1; t <= 30; t++) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL combo_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (TC && tc_rise < 0) tc_rise = t;
            if (Up) begin
                nu++;
                up_t = t;
                up_tc = TC;
            end
        end
        checks++;
        if (tc_rise != 10) begin
            errors++;
            $display("FAIL combo_tc_latency: got %0d expected 10", tc_rise);
        end
        checks++;
        if (nu != 1 || up_t != 11) begin
            errors++;
            $display("FAIL combo_up_strobe: got count %0d at %0d expected count 1 at 11", nu, up_t);
        end
        checks++;
        if (up_tc !== 1'b1) begin
            errors++;
            $display("FAIL combo_selector_first: got TC=%b during strobe expected 1", up_tc);
        end
        btn_tc = 1'b0;
        btn_up = 1'b0;
        nu = 0;
        repeat (20) begin
            tick();
            if (Up) nu++;
        end
        checks++;
        if (TC !== 1'b0 || nu != 0) begin
            errors++;
            $display("FAIL combo_release: got TC=%b strobes=%0d expected TC=0 strobes=0", TC, nu);
        end
    endtask

    task automatic test_conflict();
        int n1, n2;
        n1 = 0;
        n2 = 0;
        btn_up = 1'b1;
        btn_down = 1'b1;
        repeat (20) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL conflict_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (Up || Down) n1++;
        end
        btn_down = 1'b0;
        repeat (20) begin
            tick();
            if (Up || Down) n2++;
        end
        checks++;
        if (n1 != 0) begin
            errors++;
            $display("FAIL conflict_together: got %0d strobes expected 0", n1);
        end
        checks++;
        if (n2 != 0) begin
            errors++;
            $display("FAIL conflict_release_down: got %0d strobes expected 0", n2);
        end
        btn_up = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_hold_other();
        int n1, n2, n3;
        n1 = 0;
        n2 = 0;
        n3 = 0;
        btn_down = 1'b1;
        repeat (20) tick();
        btn_up = 1'b1;
        repeat (20) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL hold_other_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (Up) n1++;
        end
        btn_down = 1'b0;
        repeat (20) begin
            tick();
            if (Up) n2++;
        end
        btn_up = 1'b0;
        repeat (20) tick();
        btn_up = 1'b1;
        repeat (20) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL repress_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (Up) n3++;
        end
        checks++;
        if (n1 != 0 || n2 != 0) begin
            errors++;
            $display("FAIL other_held_no_up: got %0d and %0d strobes expected 0 and 0", n1, n2);
        end
        checks++;
        if (n3 != 1) begin
            errors++;
            $display("FAIL repress_one_up: got %0d strobes expected 1", n3);
        end
        btn_up = 1'b0;
        repeat (20) tick();
    endtask

    task automatic test_reset_mid();
        int n;
        n = 0;
        btn_up = 1'b1;
        btn_tc = 1'b1;
        repeat (6) tick();
        reset = 1'b0;
        model_clear();
        #2;
        checks++;
        if ({Up, Down, TC, Lp} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_mid_async: got %b expected 0000", {Up, Down, TC, Lp});
        end
        btn_up = 1'b0;
        btn_tc = 1'b0;
        repeat (2) tick();
        reset = 1'b1;
        repeat (30) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL reset_mid_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (Up || Down || TC) n++;
        end
        checks++;
        if (n != 0) begin
            errors++;
            $display("FAIL reset_mid_quiet: got %0d active cycles expected 0", n);
        end
    endtask

    task automatic test_random();
        int hold [4];
        logic [3:0] lv;
        lv = '0;
        for (int c = 0; c < 4; c++) hold[c] = 1;
        repeat (1500) begin
            for (int c = 0; c < 4; c++) begin
                hold[c]--;
                if (hold[c] <= 0) begin
                    lv[c] = 1'($urandom_range(0, 1));
                    hold[c] = $urandom_range(1, 20);
                end
            end
            {btn_lp, btn_tc, btn_down, btn_up} = lv;
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL random_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
        end
        {btn_lp, btn_tc, btn_down, btn_up} = 4'b0000;
        repeat (25) tick();
    endtask

`ifdef BTN_AUTOREPEAT_EN
    task automatic test_autorepeat();
        int offs [$];
        int found, early, late;
        found = 0;
        early = 0;
        late = 0;
        btn_down = 1'b1;
        for (int t = 0; t < 30 && found == 0; t++) begin
            tick();
            if (Down) found = 1;
        end
        checks++;
        if (found == 0) begin
            errors++;
            $display("FAIL rpt_first: got no strobe within 30 cycles expected one");
        end
        for (int t = 1; t <= 60; t++) begin
            tick();
            checks++;
            if ({Up, Down, TC, Lp} !== exp_out) begin
                errors++;
                $display("FAIL rpt_model at %0t: got %b expected %b", $time, {Up, Down, TC, Lp}, exp_out);
            end
            if (Down) offs.push_back(t);
        end
        checks++;
        if (offs.size() != 7) begin
            errors++;
            $display("FAIL rpt_count: got %0d repeats expected 7", offs.size());
        end
        for (int i = 0; i < offs.size(); i++) begin
            checks++;
            if (offs[i] != int'(RD) + i * int'(RP)) begin
                errors++;
                $display("FAIL rpt_offset[%0d]: got %0d expected %0d", i, offs[i], int'(RD) + i * int'(RP));
            end
        end
        btn_down = 1'b0;
        for (int t = 1; t <= 30; t++) begin
            tick();
            if (Down && t <= 10) early++;
            if (Down && t > 10) late++;
        end
        checks++;
        if (early != 2 || late != 0) begin
            errors++;
            $display("FAIL rpt_stop: got %0d before and %0d after release expected 2 and 0", early, late);
        end
    endtask
`endif

    initial begin
        model_clear();
        test_reset();
        test_bounce();
        test_combo();
        test_conflict();
        test_hold_other();
        test_reset_mid();
        test_random();
`ifdef BTN_AUTOREPEAT_EN
        test_autorepeat();
`endif
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
